// File: rtl/conv_pkg.sv
// Shared definitions for the convolution core: default widths, the
// sequencer state encoding and a constant-evaluable clog2 helper.
package conv_pkg;

    localparam int DEPTHWIDTH_DEF = 9;
    localparam int CNTWIDTH_DEF   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 for sizing counters from element counts.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_wrap.sv
// Loop counter: advances on enable, wraps to zero after reaching i_max and
// raises a carry in the enabled cycle that performs the wrap.
module cnt_wrap
    import conv_pkg::*;
#(
    parameter int CNTWIDTH = CNTWIDTH_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [CNTWIDTH-1:0] i_max,
    output logic [CNTWIDTH-1:0] o_cnt,
    output logic                o_carry
);

    logic [CNTWIDTH-1:0] r_cnt;
    logic                w_at_max;

    assign w_at_max = (r_cnt == i_max);
    assign o_carry  = i_en && w_at_max;
    assign o_cnt    = r_cnt;

    // Step the count on enable, folding back to zero after the maximum.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_max ? '0 : r_cnt + CNTWIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_rd_addr_gen.sv
// Read-address generator for the feature and weight buffers. Walks
// wog > cog > ky > kx > cig and emits one registered address pair per step.
//
// Handshake: a beat is transferred in any cycle with O_rd_dv=1 and
// I_rd_ready=1. Once O_rd_dv is high the beat and its markers hold stable
// until transferred. The loop counters always describe the next beat to be
// loaded into the output register, so they run one step ahead of the beat
// on the port and freeze together with it during a stall.
module conv_rd_addr_gen
    import conv_pkg::*;
#(
    parameter int DEPTHWIDTH = DEPTHWIDTH_DEF,
    parameter int CNTWIDTH   = CNTWIDTH_DEF
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_start,
    input  logic [CNTWIDTH-1:0]   I_wo_group,
    input  logic [CNTWIDTH-1:0]   I_co_group,
    input  logic [CNTWIDTH-1:0]   I_ky_num,
    input  logic [CNTWIDTH-1:0]   I_kx_num,
    input  logic [CNTWIDTH-1:0]   I_ci_group,
    input  logic [DEPTHWIDTH-1:0] I_frow_pitch,
    input  logic                  I_rd_ready,
    output logic                  O_rd_dv,
    output logic [DEPTHWIDTH-1:0] O_rd_fdepth,
    output logic [DEPTHWIDTH-1:0] O_rd_wdepth,
    output logic                  O_acc_clr,
    output logic                  O_acc_last,
    output logic                  O_busy,
    output logic                  O_done,
    output logic                  O_cfg_err
);

    localparam logic [DEPTHWIDTH-1:0] ONE_D = DEPTHWIDTH'(1);
    localparam logic [CNTWIDTH-1:0]   ONE_C = CNTWIDTH'(1);

    // Sequencer state
    state_t r_state;
    state_t w_state_nxt;
    logic   w_busy;
    logic   w_done;
    logic   w_cfg_err;

    // Latched configuration
    logic [CNTWIDTH-1:0]   r_wo;
    logic [CNTWIDTH-1:0]   r_co;
    logic [CNTWIDTH-1:0]   r_ky;
    logic [CNTWIDTH-1:0]   r_kx;
    logic [CNTWIDTH-1:0]   r_ci;
    logic [DEPTHWIDTH-1:0] r_pitch;
    logic                  r_cfg_err;

    // Loop counters and carries
    logic [CNTWIDTH-1:0] w_cig_cnt;
    logic [CNTWIDTH-1:0] w_kx_cnt;
    logic [CNTWIDTH-1:0] w_ky_cnt;
    logic [CNTWIDTH-1:0] w_cog_cnt;
    logic [CNTWIDTH-1:0] w_unused_wog_cnt;
    logic                w_c_cig;
    logic                w_c_kx;
    logic                w_c_ky;
    logic                w_c_cog;
    logic                w_c_wog;

    // Running address bases
    logic [DEPTHWIDTH-1:0] r_f_inner;  // kx*ci + cig
    logic [DEPTHWIDTH-1:0] r_f_ky;     // ky*pitch
    logic [DEPTHWIDTH-1:0] r_f_wog;    // wog*kx*ci
    logic [DEPTHWIDTH-1:0] r_w_s;      // ((ky*kx + kx)*ci + cig)*co
    logic [DEPTHWIDTH-1:0] w_fdepth;
    logic [DEPTHWIDTH-1:0] w_wdepth;

    // Beat pipeline control
    logic                  r_pend;     // beats remain to be loaded
    logic                  r_fin;      // beat on the port is the final one
    logic                  r_dv;
    logic [DEPTHWIDTH-1:0] r_fdepth;
    logic [DEPTHWIDTH-1:0] r_wdepth;
    logic                  r_clr;
    logic                  r_last;
    logic                  w_start_ok;
    logic                  w_zero;
    logic                  w_accept;
    logic                  w_load;

    assign w_start_ok = (r_state == IDLE) && I_start;
    assign w_zero     = (I_wo_group == '0) || (I_co_group == '0) ||
                        (I_ky_num == '0) || (I_kx_num == '0) ||
                        (I_ci_group == '0);
    assign w_accept   = r_dv && I_rd_ready;
    assign w_load     = (r_state == RUN) && r_pend && (!r_dv || I_rd_ready);

    cnt_wrap #(.CNTWIDTH(CNTWIDTH)) u_cnt_cig (
        .i_clk  (I_clk),
        .i_rst  (I_rst),
        .i_clr  (w_start_ok),
        .i_en   (w_load),
        .i_max  (r_ci - ONE_C),
        .o_cnt  (w_cig_cnt),
        .o_carry(w_c_cig)
    );

    cnt_wrap #(.CNTWIDTH(CNTWIDTH)) u_cnt_kx (
        .i_clk  (I_clk),
        .i_rst  (I_rst),
        .i_clr  (w_start_ok),
        .i_en   (w_c_cig),
        .i_max  (r_kx - ONE_C),
        .o_cnt  (w_kx_cnt),
        .o_carry(w_c_kx)
    );

    cnt_wrap #(.CNTWIDTH(CNTWIDTH)) u_cnt_ky (
        .i_clk  (I_clk),
        .i_rst  (I_rst),
        .i_clr  (w_start_ok),
        .i_en   (w_c_kx),
        .i_max  (r_ky - ONE_C),
        .o_cnt  (w_ky_cnt),
        .o_carry(w_c_ky)
    );

    cnt_wrap #(.CNTWIDTH(CNTWIDTH)) u_cnt_cog (
        .i_clk  (I_clk),
        .i_rst  (I_rst),
        .i_clr  (w_start_ok),
        .i_en   (w_c_ky),
        .i_max  (r_co - ONE_C),
        .o_cnt  (w_cog_cnt),
        .o_carry(w_c_cog)
    );

    cnt_wrap #(.CNTWIDTH(CNTWIDTH)) u_cnt_wog (
        .i_clk  (I_clk),
        .i_rst  (I_rst),
        .i_clr  (w_start_ok),
        .i_en   (w_c_cog),
        .i_max  (r_wo - ONE_C),
        .o_cnt  (w_unused_wog_cnt),
        .o_carry(w_c_wog)
    );

    assign w_fdepth = r_f_ky + r_f_wog + r_f_inner;
    assign w_wdepth = r_w_s + DEPTHWIDTH'(w_cog_cnt);

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_cfg_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (I_start) begin
                    w_state_nxt = w_zero ? DONE : RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_accept && r_fin) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_cfg_err   = r_cfg_err;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture configuration on an accepted start.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_wo      <= '0;
            r_co      <= '0;
            r_ky      <= '0;
            r_kx      <= '0;
            r_ci      <= '0;
            r_pitch   <= '0;
            r_cfg_err <= 1'b0;
        end else if (w_start_ok) begin
            r_wo      <= I_wo_group;
            r_co      <= I_co_group;
            r_ky      <= I_ky_num;
            r_kx      <= I_kx_num;
            r_ci      <= I_ci_group;
            r_pitch   <= I_frow_pitch;
            r_cfg_err <= w_zero;
        end
    end

    // Advance the running address bases alongside the loop counters.
    always_ff @(posedge I_clk) begin
        if (I_rst || w_start_ok) begin
            r_f_inner <= '0;
            r_f_ky    <= '0;
            r_f_wog   <= '0;
            r_w_s     <= '0;
        end else if (w_load) begin
            r_f_inner <= w_c_kx ? '0 : r_f_inner + ONE_D;
            if (w_c_ky) begin
                r_f_ky <= '0;
            end else if (w_c_kx) begin
                r_f_ky <= r_f_ky + r_pitch;
            end
            // At a cog carry the inner offset sits at kx*ci-1.
            if (w_c_wog) begin
                r_f_wog <= '0;
            end else if (w_c_cog) begin
                r_f_wog <= r_f_wog + r_f_inner + ONE_D;
            end
            r_w_s <= w_c_ky ? '0 : r_w_s + DEPTHWIDTH'(r_co);
        end
    end

    // Track whether beats remain to be loaded.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_pend <= 1'b0;
        end else if (w_start_ok) begin
            r_pend <= !w_zero;
        end else if (w_load && w_c_wog) begin
            r_pend <= 1'b0;
        end
    end

    // Output beat register: load the next beat when the port is free.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_dv     <= 1'b0;
            r_fdepth <= '0;
            r_wdepth <= '0;
            r_clr    <= 1'b0;
            r_last   <= 1'b0;
            r_fin    <= 1'b0;
        end else if (w_load) begin
            r_dv     <= 1'b1;
            r_fdepth <= w_fdepth;
            r_wdepth <= w_wdepth;
            r_clr    <= (w_ky_cnt == '0) && (w_kx_cnt == '0) && (w_cig_cnt == '0);
            r_last   <= w_c_ky;
            r_fin    <= w_c_wog;
        end else if (w_accept) begin
            r_dv <= 1'b0;
        end
    end

    assign O_rd_dv     = r_dv;
    assign O_rd_fdepth = r_fdepth;
    assign O_rd_wdepth = r_wdepth;
    assign O_acc_clr   = r_clr;
    assign O_acc_last  = r_last;
    assign O_busy      = w_busy;
    assign O_done      = w_done;
    assign O_cfg_err   = w_cfg_err;

endmodule

// File: tb/tb_conv_rd_addr_gen.sv
// Directed bench for conv_rd_addr_gen: address sequences, markers, flow
// control, zero-count configuration and reset abort.
module tb_conv_rd_addr_gen;

    logic       I_clk;
    logic       I_rst;
    logic       I_start;
    logic [8:0] I_wo_group;
    logic [8:0] I_co_group;
    logic [8:0] I_ky_num;
    logic [8:0] I_kx_num;
    logic [8:0] I_ci_group;
    logic [8:0] I_frow_pitch;
    logic       I_rd_ready;
    logic       O_rd_dv;
    logic [8:0] O_rd_fdepth;
    logic [8:0] O_rd_wdepth;
    logic       O_acc_clr;
    logic       O_acc_last;
    logic       O_busy;
    logic       O_done;
    logic       O_cfg_err;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_f_q[$];
    logic [8:0] exp_w_q[$];
    logic       exp_clr_q[$];
    logic       exp_last_q[$];

    conv_rd_addr_gen #(.DEPTHWIDTH(9), .CNTWIDTH(9)) dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_start     (I_start),
        .I_wo_group  (I_wo_group),
        .I_co_group  (I_co_group),
        .I_ky_num    (I_ky_num),
        .I_kx_num    (I_kx_num),
        .I_ci_group  (I_ci_group),
        .I_frow_pitch(I_frow_pitch),
        .I_rd_ready  (I_rd_ready),
        .O_rd_dv     (O_rd_dv),
        .O_rd_fdepth (O_rd_fdepth),
        .O_rd_wdepth (O_rd_wdepth),
        .O_acc_clr   (O_acc_clr),
        .O_acc_last  (O_acc_last),
        .O_busy      (O_busy),
        .O_done      (O_done),
        .O_cfg_err   (O_cfg_err)
    );

    // Clock
    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Reference address sequence from the closed-form expressions.
    task automatic fill_model(input int wo, input int co, input int ky,
                              input int kx, input int ci, input int pitch);
        for (int wg = 0; wg < wo; wg++)
            for (int cg = 0; cg < co; cg++)
                for (int k = 0; k < ky; k++)
                    for (int x = 0; x < kx; x++)
                        for (int c = 0; c < ci; c++) begin
                            exp_f_q.push_back(9'(k*pitch + wg*kx*ci + x*ci + c));
                            exp_w_q.push_back(9'(((k*kx + x)*ci + c)*co + cg));
                            exp_clr_q.push_back(k == 0 && x == 0 && c == 0);
                            exp_last_q.push_back(k == ky-1 && x == kx-1 && c == ci-1);
                        end
    endtask

    task automatic clear_model();
        exp_f_q.delete();
        exp_w_q.delete();
        exp_clr_q.delete();
        exp_last_q.delete();
    endtask

    // Launch a run and consume every beat, checking it against the queues.
    task automatic run_and_check(input string name, input int wo, input int co,
                                 input int ky, input int kx, input int ci,
                                 input int pitch, input bit stall, input bit poke);
        int n_exp;
        int n_acc;
        int last_acc;
        int done_cyc;
        bit stalled;
        bit seen_done;
        bit poked;
        logic [8:0] h_f, h_w, e_f, e_w;
        logic h_clr, h_last, e_clr, e_last;
        n_exp = exp_f_q.size();
        n_acc = 0; last_acc = -10; done_cyc = -1;
        stalled = 1'b0; seen_done = 1'b0; poked = 1'b0;
        h_f = '0; h_w = '0; h_clr = 1'b0; h_last = 1'b0;
        @(negedge I_clk);
        I_wo_group = 9'(wo); I_co_group = 9'(co); I_ky_num = 9'(ky);
        I_kx_num = 9'(kx); I_ci_group = 9'(ci); I_frow_pitch = 9'(pitch);
        I_start = 1'b1; I_rd_ready = 1'b1;
        @(negedge I_clk);
        I_start = 1'b0;
        checks++;
        if (O_rd_dv !== 1'b0 || O_busy !== 1'b1)
            begin errors++; $display("FAIL %s launch: dv=%b busy=%b, required dv=0 busy=1", name, O_rd_dv, O_busy); end
        for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
            @(negedge I_clk);
            if (stall) I_rd_ready = 1'($urandom_range(0, 1));
            if (poke && n_acc == 3 && !poked) begin
                I_start = 1'b1; I_kx_num = 9'd1; I_ci_group = 9'd7; I_frow_pitch = 9'd5;
                poked = 1'b1;
            end else begin
                I_start = 1'b0;
            end
            if (cyc == 0) begin
                checks++;
                if (O_rd_dv !== 1'b1)
                    begin errors++; $display("FAIL %s first_beat_latency: dv=%b, required 1", name, O_rd_dv); end
            end
            if (stalled) begin
                checks++;
                if ({O_rd_dv, O_rd_fdepth, O_rd_wdepth, O_acc_clr, O_acc_last} !==
                    {1'b1, h_f, h_w, h_clr, h_last})
                    begin errors++; $display("FAIL %s stall_hold: dv=%b f=%0d w=%0d, required dv=1 f=%0d w=%0d",
                                             name, O_rd_dv, O_rd_fdepth, O_rd_wdepth, h_f, h_w); end
            end
            stalled = 1'b0;
            if (O_done === 1'b1) begin
                seen_done = 1'b1;
                done_cyc = cyc;
            end else if (O_rd_dv === 1'b1) begin
                if (I_rd_ready) begin
                    checks++;
                    if (exp_f_q.size() == 0) begin
                        errors++; $display("FAIL %s extra_beat: f=%0d w=%0d, required no beat", name, O_rd_fdepth, O_rd_wdepth);
                    end else begin
                        e_f = exp_f_q.pop_front(); e_w = exp_w_q.pop_front();
                        e_clr = exp_clr_q.pop_front(); e_last = exp_last_q.pop_front();
                        if (O_rd_fdepth !== e_f || O_rd_wdepth !== e_w || O_acc_clr !== e_clr || O_acc_last !== e_last)
                            begin errors++; $display("FAIL %s beat%0d: f=%0d w=%0d clr=%b last=%b, required f=%0d w=%0d clr=%b last=%b",
                                                     name, n_acc, O_rd_fdepth, O_rd_wdepth, O_acc_clr, O_acc_last, e_f, e_w, e_clr, e_last); end
                    end
                    n_acc++;
                    last_acc = cyc;
                end else begin
                    stalled = 1'b1;
                    h_f = O_rd_fdepth; h_w = O_rd_wdepth; h_clr = O_acc_clr; h_last = O_acc_last;
                end
            end
        end
        checks++;
        if (!seen_done)
            begin errors++; $display("FAIL %s timeout: done=0, required done within 600 cycles", name); end
        checks++;
        if (n_acc != n_exp)
            begin errors++; $display("FAIL %s beat_count: %0d, required %0d", name, n_acc, n_exp); end
        if (seen_done) begin
            checks++;
            if (O_rd_dv !== 1'b0 || O_cfg_err !== 1'b0 || done_cyc != last_acc + 1 || (!stall && done_cyc != n_exp))
                begin errors++; $display("FAIL %s done_timing: dv=%b err=%b done_cyc=%0d last_acc=%0d, required dv=0 err=0 done one cycle after last beat",
                                         name, O_rd_dv, O_cfg_err, done_cyc, last_acc); end
            @(negedge I_clk);
            checks++;
            if (O_busy !== 1'b0 || O_done !== 1'b0)
                begin errors++; $display("FAIL %s after_done: busy=%b done=%b, required 0 0", name, O_busy, O_done); end
        end
        I_rd_ready = 1'b1;
        I_start = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        repeat (3) @(negedge I_clk);
        checks++;
        if ({O_rd_dv, O_rd_fdepth, O_rd_wdepth, O_acc_clr, O_acc_last, O_busy, O_done, O_cfg_err} !== 24'd0)
            begin errors++; $display("FAIL reset_outputs: dv=%b f=%0d w=%0d busy=%b done=%b err=%b, required all 0",
                                     O_rd_dv, O_rd_fdepth, O_rd_wdepth, O_busy, O_done, O_cfg_err); end
        I_rst = 1'b0;
        @(negedge I_clk);
        checks++;
        if (O_busy !== 1'b0 || O_rd_dv !== 1'b0)
            begin errors++; $display("FAIL idle_after_reset: busy=%b dv=%b, required 0 0", O_busy, O_rd_dv); end
    endtask

    task automatic test_basic();
        fill_model(2, 2, 1, 3, 2, 0);
        run_and_check("basic", 2, 2, 1, 3, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ky_pitch();
        exp_f_q = '{9'd0, 9'd100, 9'd200};
        exp_w_q = '{9'd0, 9'd1, 9'd2};
        exp_clr_q = '{1'b1, 1'b0, 1'b0};
        exp_last_q = '{1'b0, 1'b0, 1'b1};
        run_and_check("ky_pitch", 1, 1, 3, 1, 1, 100, 1'b0, 1'b0);
    endtask

    task automatic test_addr_wrap();
        exp_f_q = '{9'd0, 9'd300, 9'd88};
        exp_w_q = '{9'd0, 9'd1, 9'd2};
        exp_clr_q = '{1'b1, 1'b0, 1'b0};
        exp_last_q = '{1'b0, 1'b0, 1'b1};
        run_and_check("addr_wrap", 1, 1, 3, 1, 1, 300, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_model(2, 2, 1, 3, 2, 0);
        run_and_check("backpressure", 2, 2, 1, 3, 2, 0, 1'b1, 1'b0);
    endtask

    task automatic test_zero_cfg();
        @(negedge I_clk);
        I_wo_group = 9'd2; I_co_group = 9'd2; I_ky_num = 9'd1;
        I_kx_num = 9'd0; I_ci_group = 9'd2; I_frow_pitch = 9'd0;
        I_start = 1'b1;
        @(negedge I_clk);
        I_start = 1'b0;
        checks++;
        if (O_done !== 1'b1 || O_cfg_err !== 1'b1 || O_busy !== 1'b1 || O_rd_dv !== 1'b0)
            begin errors++; $display("FAIL zero_cfg_done: done=%b err=%b busy=%b dv=%b, required 1 1 1 0",
                                     O_done, O_cfg_err, O_busy, O_rd_dv); end
        @(negedge I_clk);
        checks++;
        if (O_done !== 1'b0 || O_cfg_err !== 1'b0 || O_busy !== 1'b0 || O_rd_dv !== 1'b0)
            begin errors++; $display("FAIL zero_cfg_after: done=%b err=%b busy=%b dv=%b, required all 0",
                                     O_done, O_cfg_err, O_busy, O_rd_dv); end
    endtask

    task automatic test_reset_midrun();
        bit bad_done;
        @(negedge I_clk);
        I_wo_group = 9'd2; I_co_group = 9'd2; I_ky_num = 9'd1;
        I_kx_num = 9'd3; I_ci_group = 9'd2; I_frow_pitch = 9'd0;
        I_start = 1'b1; I_rd_ready = 1'b1;
        @(negedge I_clk);
        I_start = 1'b0;
        repeat (6) @(negedge I_clk);
        checks++;
        if (O_rd_dv !== 1'b1 || O_rd_fdepth !== 9'd5 || O_rd_wdepth !== 9'd10 || O_acc_last !== 1'b1)
            begin errors++; $display("FAIL abort_beat5: dv=%b f=%0d w=%0d last=%b, required 1 5 10 1",
                                     O_rd_dv, O_rd_fdepth, O_rd_wdepth, O_acc_last); end
        I_rst = 1'b1;
        @(negedge I_clk);
        checks++;
        if ({O_rd_dv, O_rd_fdepth, O_rd_wdepth, O_acc_clr, O_acc_last, O_busy, O_done, O_cfg_err} !== 24'd0)
            begin errors++; $display("FAIL abort_outputs: dv=%b f=%0d w=%0d busy=%b done=%b, required all 0",
                                     O_rd_dv, O_rd_fdepth, O_rd_wdepth, O_busy, O_done); end
        I_rst = 1'b0;
        bad_done = 1'b0;
        repeat (4) begin
            @(negedge I_clk);
            if (O_done !== 1'b0 || O_rd_dv !== 1'b0) bad_done = 1'b1;
        end
        checks++;
        if (bad_done)
            begin errors++; $display("FAIL abort_quiet: activity=1, required 0 after aborted run"); end
        fill_model(2, 2, 1, 3, 2, 0);
        run_and_check("restart", 2, 2, 1, 3, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        fill_model(2, 2, 1, 3, 2, 0);
        run_and_check("start_ignored", 2, 2, 1, 3, 2, 0, 1'b0, 1'b1);
    endtask

    initial begin
        I_rst = 1'b1; I_start = 1'b0; I_rd_ready = 1'b1;
        I_wo_group = '0; I_co_group = '0; I_ky_num = '0;
        I_kx_num = '0; I_ci_group = '0; I_frow_pitch = '0;
        test_reset();
        test_basic();
        test_ky_pitch();
        test_addr_wrap();
        test_backpressure();
        test_zero_cfg();
        test_reset_midrun();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_rd_addr_gen.md
# conv_rd_addr_gen

Parametrised read-address generator for the convolution core's feature and weight buffers. It walks five nested loops: output-width group, output-channel group, ky, kx, input-channel group. Each step emits one registered pair of feature-buffer and weight-buffer read addresses under valid/ready flow control, with accumulator-clear and accumulator-last markers per output group. Compared with the previous single-row generator, the ky loop is internal, the feature row pitch is programmable, and the buffer read port can apply backpressure.

## Interface
- DEPTHWIDTH, 9: buffer address width; all address arithmetic is modulo 2^DEPTHWIDTH.
- CNTWIDTH, 9: width of each loop-count input and internal counter.
- I_clk  in  1  clock.
- I_rst  in  1  reset, synchronous, active-high.
- I_start  in  1  single-cycle start pulse; sampled only when idle.
- I_wo_group, I_co_group, I_ky_num, I_kx_num, I_ci_group  in  CNTWIDTH each  loop counts; latched at accepted start.
- I_frow_pitch  in  DEPTHWIDTH  feature-buffer address stride per ky; latched at accepted start.
- I_rd_ready  in  1  buffer read port accepts the current beat.
- O_rd_dv  out  1  address beat valid.
- O_rd_fdepth, O_rd_wdepth  out  DEPTHWIDTH each  feature and weight read addresses.
- O_acc_clr  out  1  beat is the first of its (wog, cog) group.
- O_acc_last  out  1  beat is the last of its (wog, cog) group.
- O_busy  out  1  high from accepted start until done.
- O_done  out  1  single-cycle completion pulse.
- O_cfg_err  out  1  pulses with O_done when any latched count is zero.
- All outputs reset to 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: I_start latches the configuration, sets O_busy and moves to RUN. If any count is zero, the block moves to DONE instead and emits no beats.
- Loop order, outermost to innermost: wog, cog, ky, kx, cig. The innermost counter advances once per accepted beat. Each carry advances the next loop out; each counter wraps to 0 at count-1.
- fdepth = ky*I_frow_pitch + wog*I_kx_num*I_ci_group + kx*I_ci_group + cig.
- wdepth = ((ky*I_kx_num + kx)*I_ci_group + cig)*I_co_group + cog.
- Both addresses are built with running base registers and adders only. No multipliers are allowed.
- O_acc_clr is set when ky=kx=cig=0. O_acc_last is set when ky, kx and cig are all at their maximum.
- RUN → DONE on acceptance of the beat with all five counters at maximum.
- DONE lasts one cycle: O_done=1, O_busy drops, return to IDLE. O_cfg_err=1 in that cycle only on the zero-count path.
- I_start while not IDLE is ignored. Configuration inputs may change during RUN without effect.

## Timing
- Accepted start at cycle t: first beat has O_rd_dv=1 at t+2.
- A beat is accepted in any cycle with O_rd_dv=1 and I_rd_ready=1.
- Without stalls, beats are back-to-back at one per cycle. Total beats = wo*co*ky*kx*ci.
- When O_rd_dv=1 and I_rd_ready=0: all outputs hold stable and the counters freeze. O_rd_dv must not drop before acceptance.
- Last beat accepted at cycle u: O_rd_dv=0 and O_done=1 at u+1.
- Zero-count path: O_done=O_cfg_err=1 at t+1, with no beats.
- I_rst asserted in any state: next cycle all outputs are 0, state is IDLE and counters are 0. No O_done is issued for an aborted run.

## Structure
- Shared package conv_pkg holds the DEPTHWIDTH/CNTWIDTH defaults, the state enum (IDLE/RUN/DONE) and the clog2 helper used across the core.
- One sub-module, cnt_wrap: a CNTWIDTH counter with enable, max input, wrap-to-zero and a carry output. It is instantiated five times and chained by carry.

## Test plan
- wo=2, co=2, ky=1, kx=3, ci=2, pitch=0, ready=1 → 24 beats.
  - First 6 beats: fdepth 0–5, wdepth 0,2,4,6,8,10.
  - Next 6 beats: fdepth 0–5, wdepth 1,3,…,11.
  - wog=1 beats: fdepth 6–11.
  - acc_clr on beats 0,6,12,18; acc_last on beats 5,11,17,23; O_done 1 cycle after beat 23.
- ky=3, all other counts 1, pitch=100 → fdepth 0,100,200; wdepth 0,1,2; acc_clr on beat 0, acc_last on beat 2.
- DEPTHWIDTH=9, ky=3, pitch=300 → fdepth 0,300,88 (address wrap).
- Previous config with I_rd_ready toggled pseudo-randomly → identical address sequence, outputs stable during stalls, still 24 accepted beats.
- kx=0 → no O_rd_dv; O_done=O_cfg_err=1 at t+1; O_busy high for exactly 1 cycle.
- I_rst at beat 5, then a restart → outputs 0 the cycle after reset; the new run starts again at fdepth 0, wdepth 0. A second I_start mid-run is ignored (beat count unchanged).
